// File: rtl/fabric_sync_fifo.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds, occupancy count and status pulses.
module fabric_sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 1024,
    parameter int FWFT  = 0,
    parameter int AFVAL = 1020,
    parameter int AEVAL = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] DATA,
    input  logic             WE,
    input  logic             RE,
    input  logic             FLUSH,
    output logic [WIDTH-1:0] Q,
    output logic             DVLD,
    output logic             FULL,
    output logic             EMPTY,
    output logic             AFULL,
    output logic             AEMPTY,
    output logic [CNT_W-1:0] WRCNT,
    output logic             WACK,
    output logic             OVERFLOW,
    output logic             UNDERFLOW
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] ram_vis;
    logic [CNT_W-1:0] ram_vis_nxt;
    logic             wr_acc;
    logic             rd_acc;
    logic             ram_rd;
    logic             dvld_nxt;

    // Handshake: WE is a write offer taken only when FULL is low; RE is a read
    // (standard) or head acknowledge (FWFT) taken only when EMPTY is low. Both
    // flags are the pre-edge registers; a rejected request pulses an error flag.
    always_comb begin
        wr_acc      = WE & ~FULL;
        rd_acc      = RE & ~EMPTY;
        ram_rd      = 1'b0;
        dvld_nxt    = 1'b0;
        count_nxt   = WRCNT;
        ram_vis_nxt = ram_vis + CNT_W'(WACK) - CNT_W'(ram_rd);
        if (FWFT != 0) begin
            // Words become visible to the prefetch one cycle after they are written,
            // so the RAM never reads an address on the edge it is written.
            ram_rd      = (ram_vis != '0) && (!DVLD || rd_acc);
            dvld_nxt    = ram_rd | (DVLD & ~rd_acc);
            ram_vis_nxt = ram_vis + CNT_W'(WACK) - CNT_W'(ram_rd);
        end else begin
            ram_rd   = rd_acc;
            dvld_nxt = rd_acc;
        end
        if (wr_acc && !rd_acc) begin
            count_nxt = WRCNT + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = WRCNT - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET_N && !FLUSH && wr_acc) begin
            mem[wr_ptr] <= DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N || FLUSH) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_vis   <= '0;
            WRCNT     <= '0;
            Q         <= '0;
            DVLD      <= 1'b0;
            FULL      <= 1'b0;
            EMPTY     <= 1'b1;
            AFULL     <= 1'b0;
            AEMPTY    <= 1'b1;
            WACK      <= 1'b0;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
                Q      <= mem[rd_ptr];
            end
            ram_vis   <= ram_vis_nxt;
            WRCNT     <= count_nxt;
            DVLD      <= dvld_nxt;
            FULL      <= (count_nxt == CNT_W'(DEPTH));
            AFULL     <= (count_nxt >= CNT_W'(AFVAL));
            AEMPTY    <= (count_nxt <= CNT_W'(AEVAL));
            EMPTY     <= (FWFT != 0) ? !dvld_nxt : (count_nxt == '0);
            WACK      <= wr_acc;
            OVERFLOW  <= WE & FULL;
            UNDERFLOW <= RE & EMPTY;
        end
    end

endmodule
